// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: micro-op encodings, RV32I opcodes and queue entry types
// shared by the decode queue, its field decoder and its bus interface.
package decode_queue_pkg;

    localparam int ROB_ADDR_W = 4;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    // Ops are grouped by format so range compares classify them.
    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_EXIT
    } op_e;

    typedef enum logic [2:0] {
        TY_ELSE   = 3'd0,
        TY_BRANCH = 3'd1,
        TY_LOAD   = 3'd2,
        TY_STORE  = 3'd3,
        TY_TOREG  = 3'd4,
        TY_EXIT   = 3'd5
    } type_e;

    typedef enum logic [1:0] {
        TGT_ROB_ONLY = 2'd0,
        TGT_RS       = 2'd1,
        TGT_LSB      = 2'd2
    } target_e;

    typedef struct packed {
        op_e         op;
        type_e       ty;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_rs1;
        logic        use_rs2;
        logic [31:0] imm;
        target_e     tgt;
    } uop_t;

    typedef struct packed {
        uop_t        u;
        logic [31:0] pc;
        logic        pred_taken;
    } entry_t;

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch, register-file, RoB-bypass and dispatch signals of the
// decode queue; slave is the queue side, master the surrounding pipeline.
interface decode_queue_if
    import decode_queue_pkg::*;
#(
    parameter int ROB_W = ROB_ADDR_W
);
    logic             if_valid, if_pred_taken, if_ready, redir_valid;
    logic [31:0]      if_instr, if_pc, redir_pc;
    logic [4:0]       rf_rs1, rf_rs2;
    logic [31:0]      rf_val1, rf_val2;
    logic             rf_has_rely1, rf_has_rely2;
    logic [ROB_W-1:0] rf_rely1, rf_rely2, rob_id1, rob_id2;
    logic             rob_id1_ready, rob_id2_ready;
    logic [31:0]      rob_id1_value, rob_id2_value;
    logic             rob_full, rs_full, lsb_full;
    logic [ROB_W-1:0] rob_index;
    logic             rob_valid, rs_valid, lsb_valid;
    logic [5:0]       d_op;
    logic [2:0]       d_type;
    logic [4:0]       d_rd;
    logic [31:0]      d_pc, d_imm, d_val1, d_val2, d_rob_value, d_br_target;
    logic [ROB_W-1:0] d_rely1, d_rely2, d_rob_idx;
    logic             d_has_rely1, d_has_rely2, d_rob_ready, d_pred_taken;

    modport slave (
        input  if_valid, if_instr, if_pc, if_pred_taken,
        output if_ready, redir_valid, redir_pc,
        output rf_rs1, rf_rs2,
        input  rf_val1, rf_val2, rf_has_rely1, rf_has_rely2, rf_rely1, rf_rely2,
        output rob_id1, rob_id2,
        input  rob_id1_ready, rob_id2_ready, rob_id1_value, rob_id2_value,
        input  rob_full, rs_full, lsb_full, rob_index,
        output rob_valid, rs_valid, lsb_valid,
        output d_op, d_type, d_rd, d_pc, d_imm, d_val1, d_val2, d_rely1, d_rely2,
        output d_has_rely1, d_has_rely2, d_rob_ready, d_rob_value, d_br_target,
        output d_pred_taken, d_rob_idx
    );

    modport master (
        output if_valid, if_instr, if_pc, if_pred_taken,
        input  if_ready, redir_valid, redir_pc,
        input  rf_rs1, rf_rs2,
        output rf_val1, rf_val2, rf_has_rely1, rf_has_rely2, rf_rely1, rf_rely2,
        input  rob_id1, rob_id2,
        output rob_id1_ready, rob_id2_ready, rob_id1_value, rob_id2_value,
        output rob_full, rs_full, lsb_full, rob_index,
        input  rob_valid, rs_valid, lsb_valid,
        input  d_op, d_type, d_rd, d_pc, d_imm, d_val1, d_val2, d_rely1, d_rely2,
        input  d_has_rely1, d_has_rely2, d_rob_ready, d_rob_value, d_br_target,
        input  d_pred_taken, d_rob_idx
    );
endinterface

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational RV32I word to micro-op fields;
// anything unrecognised becomes an Exit micro-op bound for the RoB only.
module instr_field_decode
    import decode_queue_pkg::*;
(
    input  logic [31:0] instr_i,
    output uop_t        uop_o
);
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        alt, is_r, is_sh, use1, use2;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
    op_e         op;
    type_e       ty;
    target_e     tgt;

    assign opc   = instr_i[6:0];
    assign f3    = instr_i[14:12];
    assign alt   = instr_i[30];
    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

    always_comb begin
        op = OP_EXIT;
        case (opc)
            OPC_LUI:    op = OP_LUI;
            OPC_AUIPC:  op = OP_AUIPC;
            OPC_JAL:    op = OP_JAL;
            OPC_JALR:   op = f3 == 3'd0 ? OP_JALR : OP_EXIT;
            OPC_BRANCH:
                case (f3)
                    3'd0:    op = OP_BEQ;
                    3'd1:    op = OP_BNE;
                    3'd4:    op = OP_BLT;
                    3'd5:    op = OP_BGE;
                    3'd6:    op = OP_BLTU;
                    3'd7:    op = OP_BGEU;
                    default: op = OP_EXIT;
                endcase
            OPC_LOAD:
                case (f3)
                    3'd0:    op = OP_LB;
                    3'd1:    op = OP_LH;
                    3'd2:    op = OP_LW;
                    3'd4:    op = OP_LBU;
                    3'd5:    op = OP_LHU;
                    default: op = OP_EXIT;
                endcase
            OPC_STORE:
                case (f3)
                    3'd0:    op = OP_SB;
                    3'd1:    op = OP_SH;
                    3'd2:    op = OP_SW;
                    default: op = OP_EXIT;
                endcase
            OPC_IMM:
                case (f3)
                    3'd0:    op = OP_ADDI;
                    3'd1:    op = OP_SLLI;
                    3'd2:    op = OP_SLTI;
                    3'd3:    op = OP_SLTIU;
                    3'd4:    op = OP_XORI;
                    3'd5:    op = alt ? OP_SRAI : OP_SRLI;
                    3'd6:    op = OP_ORI;
                    default: op = OP_ANDI;
                endcase
            OPC_REG:
                case (f3)
                    3'd0:    op = alt ? OP_SUB : OP_ADD;
                    3'd1:    op = OP_SLL;
                    3'd2:    op = OP_SLT;
                    3'd3:    op = OP_SLTU;
                    3'd4:    op = OP_XOR;
                    3'd5:    op = alt ? OP_SRA : OP_SRL;
                    3'd6:    op = OP_OR;
                    default: op = OP_AND;
                endcase
            default:    op = OP_EXIT;
        endcase
    end

    assign ty    = op <= OP_JAL ? TY_TOREG : op == OP_JALR ? TY_ELSE : op <= OP_BGEU ? TY_BRANCH :
                   op <= OP_LHU ? TY_LOAD : op <= OP_SW ? TY_STORE : op == OP_EXIT ? TY_EXIT : TY_ELSE;
    assign is_r  = op >= OP_ADD && op <= OP_AND;
    assign is_sh = op == OP_SLLI || op == OP_SRLI || op == OP_SRAI;
    assign use1  = op > OP_JAL && op != OP_EXIT;
    assign use2  = ty == TY_BRANCH || ty == TY_STORE || is_r;
    assign imm   = (op == OP_LUI || op == OP_AUIPC) ? imm_u : op == OP_JAL ? imm_j :
                   ty == TY_BRANCH ? imm_b : ty == TY_STORE ? imm_s :
                   is_sh ? {27'b0, instr_i[24:20]} : (is_r || op == OP_EXIT) ? 32'b0 : imm_i;
    assign tgt   = (ty == TY_LOAD || ty == TY_STORE) ? TGT_LSB :
                   (ty == TY_TOREG || ty == TY_EXIT) ? TGT_ROB_ONLY : TGT_RS;

    assign uop_o = '{
        op:      op,
        ty:      ty,
        rd:      (ty == TY_BRANCH || ty == TY_STORE || ty == TY_EXIT) ? 5'd0 : instr_i[11:7],
        rs1:     use1 ? instr_i[19:15] : 5'd0,
        rs2:     use2 ? instr_i[24:20] : 5'd0,
        use_rs1: use1,
        use_rs2: use2,
        imm:     imm,
        tgt:     tgt
    };
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched RV32I words into a DEPTH-entry FIFO and
// dispatches the head to RoB/RS/LSB with operand bypass, redirects and flush.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = ROB_ADDR_W
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          flush_in,
    decode_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        op_e              op;
        type_e            ty;
        logic [4:0]       rd;
        logic [31:0]      pc, imm, val1, val2;
        logic [ROB_W-1:0] rely1, rely2;
        logic             has_rely1, has_rely2, rob_ready;
        logic [31:0]      rob_value, br_target;
        logic             pred_taken;
        logic [ROB_W-1:0] rob_idx;
    } disp_t;

    entry_t         mem_q [DEPTH];
    logic [PW-1:0]  head_q, tail_q;
    logic [CW-1:0]  count_q;
    disp_t          disp_q, disp_d;
    logic [2:0]     vld_q, vld_d;
    logic           redir_q, redir_d;
    logic [31:0]    redir_pc_q, val1, val2;
    logic           ready, push, pop;
    uop_t           dec;
    entry_t         hd;

    instr_field_decode u_dec (.instr_i(bus.if_instr), .uop_o(dec));

    assign hd    = mem_q[head_q];
    // Count-based readiness: a pop in the same cycle never admits a push into a full queue.
    assign ready = rst_n_in && count_q < CW'(DEPTH);
    assign push  = rdy_in && !flush_in && bus.if_valid && ready;
    assign pop   = rdy_in && !flush_in && count_q != '0 && !bus.rob_full &&
                   !(hd.u.tgt == TGT_RS && bus.rs_full) && !(hd.u.tgt == TGT_LSB && bus.lsb_full);
    assign redir_d = push && (dec.op == OP_JAL || (dec.ty == TY_BRANCH && bus.if_pred_taken));
    assign vld_d   = {pop, pop && hd.u.tgt == TGT_RS, pop && hd.u.tgt == TGT_LSB};
    assign val1    = !bus.rf_has_rely1 ? bus.rf_val1 : bus.rob_id1_ready ? bus.rob_id1_value : 32'b0;
    assign val2    = !bus.rf_has_rely2 ? bus.rf_val2 : bus.rob_id2_ready ? bus.rob_id2_value : 32'b0;

    always_comb begin
        disp_d = '{
            op:         hd.u.op,
            ty:         hd.u.ty,
            rd:         hd.u.rd,
            pc:         hd.pc,
            imm:        hd.u.imm,
            val1:       val1,
            val2:       hd.u.use_rs2 ? val2 : hd.u.imm,
            rely1:      bus.rf_rely1,
            rely2:      bus.rf_rely2,
            has_rely1:  hd.u.use_rs1 && bus.rf_has_rely1 && !bus.rob_id1_ready,
            has_rely2:  hd.u.use_rs2 && bus.rf_has_rely2 && !bus.rob_id2_ready,
            rob_ready:  hd.u.op <= OP_JAL,
            rob_value:  hd.u.op == OP_LUI ? hd.u.imm : hd.u.op == OP_AUIPC ? hd.pc + hd.u.imm :
                        (hd.u.op == OP_JAL || hd.u.op == OP_JALR) ? hd.pc + 32'd4 : 32'b0,
            br_target:  hd.pc + hd.u.imm,
            pred_taken: hd.pred_taken,
            rob_idx:    bus.rob_index
        };
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            disp_q     <= '0;
            vld_q      <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else if (rdy_in) begin
            if (push) mem_q[tail_q] <= '{u: dec, pc: bus.if_pc, pred_taken: bus.if_pred_taken};
            if (pop) disp_q <= disp_d;
            if (redir_d) redir_pc_q <= bus.if_pc + dec.imm;
            head_q  <= flush_in ? '0 : head_q + PW'(pop);
            tail_q  <= flush_in ? '0 : tail_q + PW'(push);
            count_q <= flush_in ? '0 : count_q + CW'(push) - CW'(pop);
            vld_q   <= vld_d;
            redir_q <= redir_d;
        end
    end

    assign bus.if_ready     = ready;
    assign bus.redir_valid  = redir_q;
    assign bus.redir_pc     = redir_pc_q;
    assign bus.rf_rs1       = hd.u.rs1;
    assign bus.rf_rs2       = hd.u.rs2;
    assign bus.rob_id1      = bus.rf_rely1;
    assign bus.rob_id2      = bus.rf_rely2;
    assign bus.rob_valid    = vld_q[2];
    assign bus.rs_valid     = vld_q[1];
    assign bus.lsb_valid    = vld_q[0];
    assign bus.d_op         = disp_q.op;
    assign bus.d_type       = disp_q.ty;
    assign bus.d_rd         = disp_q.rd;
    assign bus.d_pc         = disp_q.pc;
    assign bus.d_imm        = disp_q.imm;
    assign bus.d_val1       = disp_q.val1;
    assign bus.d_val2       = disp_q.val2;
    assign bus.d_rely1      = disp_q.rely1;
    assign bus.d_rely2      = disp_q.rely2;
    assign bus.d_has_rely1  = disp_q.has_rely1;
    assign bus.d_has_rely2  = disp_q.has_rely2;
    assign bus.d_rob_ready  = disp_q.rob_ready;
    assign bus.d_rob_value  = disp_q.rob_value;
    assign bus.d_br_target  = disp_q.br_target;
    assign bus.d_pred_taken = disp_q.pred_taken;
    assign bus.d_rob_idx    = disp_q.rob_idx;
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed vectors for decode_queue with hand-computed
// expectations checked by immediate assertions.
module tb_decode_queue;
    import decode_queue_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0;
    int   total = 0, bad = 0;

    decode_queue_if #(.ROB_W(4)) bus ();

    decode_queue #(.DEPTH(4), .ROB_W(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rdy_in   (rdy),
        .flush_in (flush),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic pred);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc = pc;
        bus.if_pred_taken = pred;
        step();
        bus.if_valid = 1'b0;
        bus.if_pred_taken = 1'b0;
    endtask

    initial begin
        bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.if_pred_taken = 0;
        bus.rf_val1 = 0; bus.rf_val2 = 0; bus.rf_has_rely1 = 0; bus.rf_has_rely2 = 0;
        bus.rf_rely1 = 0; bus.rf_rely2 = 0; bus.rob_id1_ready = 0; bus.rob_id2_ready = 0;
        bus.rob_id1_value = 0; bus.rob_id2_value = 0;
        bus.rob_full = 0; bus.rs_full = 0; bus.lsb_full = 0; bus.rob_index = 4'd7;

        #3;
        check("reset_if_ready", bus.if_ready, 0);
        check("reset_rob_valid", bus.rob_valid, 0);
        check("reset_redir_valid", bus.redir_valid, 0);
        check("reset_d_rob_value", bus.d_rob_value, 0);
        #9 rst_n = 1'b1;
        #1 check("post_reset_if_ready", bus.if_ready, 1);

        push(32'h123452B7, 32'h100, 1'b0);
        check("lui_not_yet", bus.rob_valid, 0);
        step();
        check("lui_rob_valid", bus.rob_valid, 1);
        check("lui_rs_valid", bus.rs_valid, 0);
        check("lui_lsb_valid", bus.lsb_valid, 0);
        check("lui_rob_ready", bus.d_rob_ready, 1);
        check("lui_rob_value", bus.d_rob_value, 32'h12345000);
        check("lui_rd", bus.d_rd, 5);
        check("lui_op", bus.d_op, OP_LUI);
        check("lui_type", bus.d_type, TY_TOREG);
        check("lui_rob_idx", bus.d_rob_idx, 7);
        rdy = 1'b0;
        step();
        check("rdy_low_hold_valid", bus.rob_valid, 1);
        rdy = 1'b1;
        step();
        check("pulse_drop", bus.rob_valid, 0);

        push(32'h020000EF, 32'h200, 1'b0);
        check("jal_redir_valid", bus.redir_valid, 1);
        check("jal_redir_pc", bus.redir_pc, 32'h220);
        step();
        check("jal_redir_drop", bus.redir_valid, 0);
        check("jal_rob_valid", bus.rob_valid, 1);
        check("jal_rob_value", bus.d_rob_value, 32'h204);
        check("jal_op", bus.d_op, OP_JAL);

        push(32'h00208863, 32'h500, 1'b1);
        check("br_taken_redir", bus.redir_valid, 1);
        check("br_taken_pc", bus.redir_pc, 32'h510);
        step();
        check("br_rs_valid", bus.rs_valid, 1);
        check("br_type", bus.d_type, TY_BRANCH);
        check("br_target", bus.d_br_target, 32'h510);
        check("br_pred", bus.d_pred_taken, 1);
        push(32'h00208863, 32'h600, 1'b0);
        check("br_nt_no_redir", bus.redir_valid, 0);
        step();

        bus.lsb_full = 1'b1;
        push(32'h0080A303, 32'h700, 1'b0);
        step();
        check("lsb_full_blocks", bus.rob_valid, 0);
        bus.lsb_full = 1'b0;
        step();
        check("lw_lsb_valid", bus.lsb_valid, 1);
        check("lw_rs_valid", bus.rs_valid, 0);
        check("lw_imm", bus.d_imm, 8);
        check("lw_rd", bus.d_rd, 6);

        bus.rs_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.if_valid = 1'b1;
            bus.if_instr = 32'h00208033 | ((i + 1) << 7);
            bus.if_pc = 32'h300 + 4 * i;
            step();
        end
        check("bp_full_if_ready", bus.if_ready, 0);
        bus.if_instr = 32'h00208033 | (5 << 7);
        bus.if_pc = 32'h310;
        step();
        check("bp_still_full", bus.if_ready, 0);
        check("bp_no_dispatch", bus.rob_valid, 0);
        bus.if_valid = 1'b0;
        bus.rs_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("bp_rs_valid", bus.rs_valid, 1);
            check("bp_order_pc", bus.d_pc, 32'h300 + 4 * k);
            check("bp_order_rd", bus.d_rd, k + 1);
        end
        step();
        check("bp_fifth_dropped", bus.rob_valid, 0);

        bus.rf_val1 = 32'hDEAD; bus.rf_has_rely1 = 1; bus.rf_rely1 = 4'd2;
        bus.rob_id1_ready = 1; bus.rob_id1_value = 32'h55;
        bus.rf_has_rely2 = 1; bus.rf_rely2 = 4'd3; bus.rob_id2_ready = 0;
        push(32'h002081B3, 32'h800, 1'b0);
        check("byp_rf_rs1", bus.rf_rs1, 1);
        check("byp_rf_rs2", bus.rf_rs2, 2);
        check("byp_rob_id1", bus.rob_id1, 2);
        step();
        check("byp_val1", bus.d_val1, 32'h55);
        check("byp_has_rely1", bus.d_has_rely1, 0);
        check("byp_has_rely2", bus.d_has_rely2, 1);
        check("byp_rely2", bus.d_rely2, 3);
        check("byp_val2", bus.d_val2, 0);
        bus.rf_val1 = 0; bus.rf_has_rely1 = 0; bus.rf_rely1 = 0; bus.rob_id1_ready = 0;
        bus.rob_id1_value = 0; bus.rf_has_rely2 = 0; bus.rf_rely2 = 0;

        bus.rs_full = 1'b1;
        for (int i = 0; i < 3; i++) push(32'h002081B3, 32'h900 + 4 * i, 1'b0);
        bus.if_valid = 1'b1;
        bus.if_instr = 32'h020000EF;
        bus.if_pc = 32'hA00;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.if_valid = 1'b0;
        check("flush_rob_valid", bus.rob_valid, 0);
        check("flush_rs_valid", bus.rs_valid, 0);
        check("flush_redir", bus.redir_valid, 0);
        check("flush_if_ready", bus.if_ready, 1);
        bus.rs_full = 1'b0;
        step();
        check("flush_empty", bus.rob_valid, 0);

        push(32'h0000007F, 32'hB00, 1'b0);
        step();
        check("ill_op", bus.d_op, OP_EXIT);
        check("ill_type", bus.d_type, TY_EXIT);
        check("ill_rob_valid", bus.rob_valid, 1);
        check("ill_rs_valid", bus.rs_valid, 0);
        check("ill_lsb_valid", bus.lsb_valid, 0);

        bus.rs_full = 1'b1;
        push(32'h002081B3, 32'hC00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("async_if_ready", bus.if_ready, 0);
        check("async_d_pc", bus.d_pc, 0);
        rst_n = 1'b1;
        bus.rs_full = 1'b0;
        step();
        check("async_queue_empty", bus.rob_valid, 0);
        check("async_ready", bus.if_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage between instruction fetch and dispatch. Decodes each fetched RV32I instruction into a micro-op and holds it in a DEPTH-entry FIFO. The FIFO decouples fetch from RoB/RS/LSB back-pressure, so no fetched instruction is lost while a unit is full. Adds, relative to the single-register decoder generation:

- queued decode
- per-unit dispatch gating
- separate Jalr handling
- illegal-op trapping to `exit_`
- full pipeline flush

## Interface

**Parameters**

- `DEPTH`, 4: queue entries. Must be a power of two ≥ 2.
- `ROB_W`, `` `RoB_addr ``: RoB index width.

**Ports**

Clock and reset (already decided):
- `clk_in` in 1: the single clock.
- `rst_n_in` in 1: asynchronous, active-low reset.

Control:
- `rdy_in` in 1: global enable. When low, all state holds.
- `flush_in` in 1: mispredict or exception flush from the RoB.

Fetch side:
- `if_valid` in 1: fetched instruction valid.
- `if_instr` in 32: instruction word.
- `if_pc` in 32: its PC.
- `if_pred_taken` in 1: branch prediction for this instruction.
- `if_ready` out 1: queue can accept.
- `redir_valid` out 1: fetch redirect, one-cycle pulse.
- `redir_pc` out 32: redirect target.

Register file lookup:
- `rf_rs1` out 5, `rf_rs2` out 5: source register indices of the head entry.
- `rf_val1` in 32, `rf_val2` in 32: register values.
- `rf_has_rely1` in 1, `rf_has_rely2` in 1: operand has a pending producer.
- `rf_rely1` in `ROB_W`, `rf_rely2` in `ROB_W`: producer RoB tags.

RoB bypass:
- `rob_id1` out `ROB_W`, `rob_id2` out `ROB_W`: tags to probe, equal to `rf_rely1`/`rf_rely2`.
- `rob_id1_ready` in 1, `rob_id2_ready` in 1: producer result available.
- `rob_id1_value` in 32, `rob_id2_value` in 32: producer results.

Dispatch:
- `rob_full` in 1, `rs_full` in 1, `lsb_full` in 1: unit full flags.
- `rob_index` in `ROB_W`: RoB slot the next dispatched micro-op will occupy.
- `rob_valid` out 1: push to the RoB.
- `rs_valid` out 1: push to the RS.
- `lsb_valid` out 1: push to the LSB.
- `d_*` out: registered micro-op bundle, made of:
  - `d_op` 6
  - `d_type` 3
  - `d_rd` 5
  - `d_pc` 32
  - `d_imm` 32
  - `d_val1` 32, `d_val2` 32
  - `d_rely1` `ROB_W`, `d_rely2` `ROB_W`
  - `d_has_rely1` 1, `d_has_rely2` 1
  - `d_rob_ready` 1, `d_rob_value` 32
  - `d_br_target` 32
  - `d_pred_taken` 1
  - `d_rob_idx` `ROB_W`

## Operation

**Decode on push.** A push occurs when `if_valid && if_ready && !flush_in`. The entry stores:

- `op` and `type`
- `rd`, `rs1`, `rs2`
- `use_rs1`, `use_rs2`
- `imm`
- `pc`, `pred_taken`
- `target`: one of ROB_ONLY, RS, LSB

Source usage:
- `use_rs2` = 1 only for B, S and R formats.
- `use_rs1` = 0 for Lui, Auipc and Jal.

Immediates:
- Shift-immediate ops use the zero-extended `shamt`.
- Loads carry `imm_I`; stores carry `imm_S`.

Unknown opcodes, or an unknown funct3 in a known format:
- `op` = `` `Exit ``, `type` = `` `exit_ ``, `target` = ROB_ONLY.

**Precomputed results.** Lui, Auipc and Jal are ROB_ONLY with `rob_ready` = 1. Their values:
- Lui: `imm_U`
- Auipc: `pc + imm_U`
- Jal: `pc + 4`

Jalr is an RS op with its own `` `Jalr `` opcode and a precomputed link value of `pc + 4`.

**Redirects.** A push of either of the following raises `redir_valid` on the next cycle with `redir_pc` set to:
- Jal: `pc + imm_J`
- branch with `pred_taken` = 1: `pc + imm_B`

All other pushes leave `redir_valid` = 0.

**Dispatch.** A dispatch occurs when all of the following hold:
- `rdy_in`
- `!flush_in`
- queue non-empty
- `!rob_full`
- head `target` = RS implies `!rs_full`
- head `target` = LSB implies `!lsb_full`

On dispatch, the head is popped and the `d_*` outputs are registered. `rob_valid` = 1, plus exactly one of `rs_valid`/`lsb_valid` for RS and LSB targets.

**Operand resolution at dispatch**, per source operand x:
- `val` = `rf_val` if `!has_rely`; otherwise `rob_value` if `rob_ready`; otherwise 0.
- `has_rely` = `use_rs` && `rf_has_rely` && `!rob_ready`.
- For an unused rs2, `d_val2` = the stored immediate.

**Flush.** The queue is emptied (pointers and count to 0). All `*_valid` outputs and `redir_valid` are 0 on the next cycle. The same-cycle push and pop are suppressed.

## Timing

**Reset.** All outputs are 0 and the queue is empty. `if_ready` is 1 once reset is released.

**Latency.** An instruction pushed at edge N is visible on the `d_*` outputs after edge N+1, at the earliest.

**Pulse outputs.** `rob_valid`, `rs_valid`, `lsb_valid` and `redir_valid` are single-cycle pulses. They drop to 0 in any cycle without a dispatch (or, for `redir_valid`, without a redirecting push).

**Queue bookkeeping.**
- `if_ready` = `count < DEPTH`. It is registered-count based, so a same-cycle pop does not admit a push into a full queue.
- A simultaneous push and pop leaves `count` unchanged.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally.
- `count` is `$clog2(DEPTH)+1` bits wide.

**Back-pressure.** A full unit blocks only the head; the queue keeps filling until full.

**`rdy_in` low.** Every register, including the pulse outputs, holds its value.

**Reset mid-operation.** Asynchronous assertion clears everything immediately, including a dispatch in flight.

## Structure

- Shared `const.v` holds:
  - opcode defines, including a distinct `` `Jalr ``
  - `type` encodings (`else_`, `branch_`, `load_`, `store_`, `toreg_`, `exit_`)
  - instruction-format opcodes
  - `` `RoB_addr ``
- Add to `const.v` the 2-bit target encoding: ROB_ONLY = 0, RS = 1, LSB = 2.
- One natural sub-module, `instr_field_decode`: purely combinational `instr` to micro-op fields. The queue, dispatch and flush logic stay in `decode_queue`.

## Test plan

- **Lui dispatch.** Push `0x123452B7` at pc `0x100`, all units empty. Required: `rob_valid` = 1 with `d_rob_ready` = 1, `d_rob_value` = `0x12345000`, `d_rd` = 5; `rs_valid` = 0; `lsb_valid` = 0.
- **Jal redirect.** Push `jal x1, +0x20` at pc `0x200`. Required: `redir_valid` pulse with `redir_pc` = `0x220`; dispatched `d_rob_value` = `0x204`.
- **Back-pressure.** Hold `rs_full` = 1 and push 5 adds with DEPTH = 4. Required: `if_ready` = 0 after 4 pushes and nothing dispatched. On release, 4 dispatches on consecutive cycles in order.
- **RoB bypass.** Dispatch `add x3, x1, x2` with x1 relying on tag 2 (ready, value `0x55`) and x2 relying on tag 3 (not ready). Required: `d_val1` = `0x55`, `d_has_rely1` = 0, `d_has_rely2` = 1, `d_rely2` = 3.
- **Flush.** Assert `flush_in` with 3 entries queued and `if_valid` high. Required: next cycle count = 0, no valids, `if_ready` = 1.
- **Illegal opcode.** Push opcode `0x7F`. Required: dispatched with `d_op` = `` `Exit ``, `d_type` = `` `exit_ ``, `rob_valid` only.
